sprite_pixel_fetch: RTL

Per-pixel sprite fetch stage that feeds a sprite's 16-entry palette. It takes the VGA draw coordinates and computes the sprite-ROM address for the current animation frame. It then returns the ROM's 4-bit colour index, aligned with an in-sprite/opaque flag, to the palette lookup and the colour mapper. It also owns the sprite's frame-synchronous position latch and the animation frame counter.

---
 rtl/sprite_pkg.sv | 8 +
 rtl/sprite_pixel_fetch_if.sv | 10 +
 rtl/sprite_anim_timer.sv | 38 +++
 rtl/sprite_pixel_fetch.sv | 77 +++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared constants and types for the sprite pixel path.
package sprite_pkg;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam logic [3:0] TRANSPARENT_IDX = 4'h1;

  typedef logic [9:0] coord_t;
endpackage

// File: rtl/sprite_pixel_fetch_if.sv
// Sprite ROM read bus: address out from the fetch stage, data back one cycle later.
interface sprite_pixel_fetch_if #(
  parameter int AW = 11
);
  logic [AW-1:0] rom_addr;
  logic [3:0]    rom_q;

  modport master (output rom_addr, input rom_q);
  modport slave  (input rom_addr, output rom_q);
endinterface

// File: rtl/sprite_anim_timer.sv
// Detects the vs falling edge and advances the animation frame every FRAME_TICKS edges.
module sprite_anim_timer #(
  parameter int FRAMES      = 2,
  parameter int FRAME_TICKS = 8,
  localparam int FW = (FRAMES > 1) ? $clog2(FRAMES) : 1,
  localparam int TW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1
) (
  input  logic          vga_clk,
  input  logic          reset_n,
  input  logic          vs,
  input  logic          anim_en,
  output logic          frame_pulse,
  output logic [FW-1:0] anim_frame
);
  logic          vs_d;
  logic [TW-1:0] tick;

  // vs_d clears in reset, so an edge that lands during reset is lost
  assign frame_pulse = vs_d & ~vs;

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      vs_d       <= 1'b0;
      tick       <= '0;
      anim_frame <= '0;
    end else begin
      vs_d <= vs;
      if (frame_pulse && anim_en) begin
        if (tick == TW'(FRAME_TICKS - 1)) begin
          tick       <= '0;
          anim_frame <= (anim_frame == FW'(FRAMES - 1)) ? '0 : anim_frame + FW'(1);
        end else begin
          tick <= tick + TW'(1);
        end
      end
    end
  end
endmodule

// File: rtl/sprite_pixel_fetch.sv
// Sprite fetch: hit test and ROM address, then the ROM read, then the colour index and
// opaque flag, giving a fixed 3-cycle latency from DrawX/DrawY to pix_index/pix_on.
module sprite_pixel_fetch
  import sprite_pkg::*;
#(
  parameter int SPR_W       = 32,
  parameter int SPR_H       = 32,
  parameter int FRAMES      = 2,
  parameter int FRAME_TICKS = 8,
  parameter int AW          = $clog2(FRAMES * SPR_W * SPR_H),
  localparam int FW = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
  input  logic                  vga_clk,
  input  logic                  reset_n,
  input  coord_t                DrawX,
  input  coord_t                DrawY,
  input  logic                  blank,
  input  logic                  vs,
  input  coord_t                pos_x,
  input  coord_t                pos_y,
  input  logic                  anim_en,
  sprite_pixel_fetch_if.master  rom,
  output logic [3:0]            pix_index,
  output logic                  pix_on,
  output logic [FW-1:0]         anim_frame
);
  logic       frame_pulse;
  coord_t     act_x, act_y;
  logic       hit, hit_d1, hit_d2;
  logic [10:0] x11, y11, ax11, ay11, dx, dy;

  sprite_anim_timer #(
    .FRAMES      (FRAMES),
    .FRAME_TICKS (FRAME_TICKS)
  ) u_timer (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .vs          (vs),
    .anim_en     (anim_en),
    .frame_pulse (frame_pulse),
    .anim_frame  (anim_frame)
  );

  // 11-bit compares keep a sprite near the right/bottom edge from wrapping to 0
  assign x11  = {1'b0, DrawX};
  assign y11  = {1'b0, DrawY};
  assign ax11 = {1'b0, act_x};
  assign ay11 = {1'b0, act_y};
  assign dx   = x11 - ax11;
  assign dy   = y11 - ay11;
  assign hit  = blank
              & (x11 >= ax11) & (x11 < ax11 + 11'(SPR_W))
              & (y11 >= ay11) & (y11 < ay11 + 11'(SPR_H));

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      act_x        <= '0;
      act_y        <= '0;
      hit_d1       <= 1'b0;
      hit_d2       <= 1'b0;
      rom.rom_addr <= '0;
      pix_index    <= '0;
      pix_on       <= 1'b0;
    end else begin
      if (frame_pulse) begin
        act_x <= pos_x;
        act_y <= pos_y;
      end
      hit_d1       <= hit;
      hit_d2       <= hit_d1;
      rom.rom_addr <= hit ? AW'(32'(anim_frame) * SPR_W * SPR_H + 32'(dy) * SPR_W + 32'(dx))
                          : '0;
      pix_index    <= hit_d2 ? rom.rom_q : 4'h0;
      pix_on       <= hit_d2 && (rom.rom_q != TRANSPARENT_IDX);
    end
  end
endmodule
